// File: rtl/sar_afe_emulator.sv
// sar_afe_emulator: digital stand-in for the SAR sample-and-hold and comparator.
// Tracks/holds an input code, answers DAC trials after a fixed latency and checks each result.
module sar_afe_emulator #(
    parameter int unsigned Width    = 6,
    parameter int unsigned Latency  = 1,
    parameter int unsigned CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    vin_i,
    input  logic [2:0]          offset_i,
    input  logic                sample_i,
    input  logic [Width-1:0]    dac_i,
    input  logic                eoc_i,
    input  logic [Width-1:0]    result_i,
    output logic                cmp_o,
    output logic [Width-1:0]    held_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [CntWidth-1:0] conv_cnt_o,
    output logic [CntWidth-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD,
        CHECK
    } state_e;

    state_e                  state_q, state_d;
    logic [Width-1:0]        held_q;
    logic                    held_load;
    logic                    check_fire;
    logic signed [Width+1:0] eff;
    logic                    raw;
    logic [Width-1:0]        exp_code;
    logic                    match;
    logic                    pass_q;
    logic [CntWidth-1:0]     conv_q;
    logic [CntWidth-1:0]     err_q;
    logic [Latency-1:0]      dly_q;

    // Two guard bits keep held + offset exact for the full -4..2^Width+2 span.
    assign eff = $signed({2'b00, held_q}) + $signed({{(Width-1){offset_i[2]}}, offset_i});
    assign raw = (eff >= $signed({2'b00, dac_i}));

    always_comb begin
        exp_code = eff[Width-1:0];
        if (eff[Width+1]) begin
            exp_code = '0;
        end else if (eff[Width]) begin
            exp_code = '1;
        end
    end

    assign match = (result_i == exp_code);

    if (Latency == 1) begin : g_lat1
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dly_q <= '0;
            end else begin
                dly_q <= raw;
            end
        end
    end else begin : g_latn
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dly_q <= '0;
            end else begin
                dly_q <= {dly_q[Latency-2:0], raw};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        held_load  = 1'b0;
        check_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_i) begin
                    state_d   = TRACK;
                    held_load = 1'b1;
                end
            end
            TRACK: begin
                if (sample_i) begin
                    held_load = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (eoc_i) begin
                    state_d    = CHECK;
                    check_fire = 1'b1;
                end else if (sample_i) begin
                    state_d   = TRACK;
                    held_load = 1'b1;
                end
            end
            CHECK: begin
                if (sample_i) begin
                    state_d   = TRACK;
                    held_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The comparison is resolved at the eoc edge (result and offset sampled there),
    // so pass and the counters are already valid during the CHECK cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            held_q  <= '0;
            pass_q  <= 1'b0;
            conv_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            if (held_load) begin
                held_q <= vin_i;
            end
            if (check_fire) begin
                pass_q <= match;
                if (conv_q != '1) begin
                    conv_q <= conv_q + CntWidth'(1);
                end
                if (!match && (err_q != '1)) begin
                    err_q <= err_q + CntWidth'(1);
                end
            end
        end
    end

    assign cmp_o      = dly_q[Latency-1];
    assign held_o     = held_q;
    assign done_o     = (state_q == CHECK);
    assign pass_o     = pass_q;
    assign conv_cnt_o = conv_q;
    assign err_cnt_o  = err_q;

endmodule

// File: doc/sar_afe_emulator.md
Name: sar_afe_emulator

Overview:
- Synthesizable digital stand-in for the analog front end (sample-and-hold plus comparator) driven by the SAR ADC controller.
- Samples a digital "analog" input code while the controller asserts sample, then holds it.
- Answers each DAC trial code with a delayed comparator decision.
- Checks the controller's final result at end-of-conversion and keeps pass and error statistics.
- Intended for silicon and bench self-test of the SAR controller without an analog macro.

Parameters:
- Width, 6, code width of vin/dac/result; must match the SAR controller.
- Latency, 1, comparator delay in clock cycles from dac_i to cmp_o; legal range 1..4.
- CntWidth, 8, width of the conversion and error counters.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- vin_i  input  Width  emulated analog input code
- offset_i  input  3  signed comparator offset in LSB, two's complement, range -4..+3
- sample_i  input  1  sample/track request from the SAR controller
- dac_i  input  Width  trial code from the SAR controller
- eoc_i  input  1  end-of-conversion from the SAR controller
- result_i  input  Width  conversion result from the SAR controller
- cmp_o  output  1  comparator decision back to the SAR controller
- held_o  output  Width  currently held sample
- done_o  output  1  one-cycle pulse when a result has been checked
- pass_o  output  1  result of the last check; valid from done_o onward
- conv_cnt_o  output  CntWidth  checked conversions, saturating
- err_cnt_o  output  CntWidth  mismatching conversions, saturating

Behaviour:
- Single clock domain. All state is updated on the rising edge of clk_i.
- Reset is synchronous and active-high. While rst_i=1 at an edge, all outputs and internal state take 0: state IDLE, held=0, delay line=0, cmp_o=0, done_o=0, pass_o=0, both counters 0. Reset mid-conversion aborts with no count update.
- Effective level: eff = held + sext(offset_i), evaluated in Width+2 signed bits. It is not clamped for comparison.
- Raw decision: raw = (eff >= zext(dac_i)).
- Comparator output: raw enters a Latency-deep shift register; cmp_o is its last stage. With Latency=1, cmp_o at cycle n+1 reflects dac_i, held and offset_i at cycle n.
- The delay line runs in every state; cmp_o in IDLE and TRACK is don't-care to the controller but is still deterministic.
- Expected code: exp = clamp(eff, 0, 2^Width-1).
- State IDLE:
  - sample_i=1 -> TRACK, held<=vin_i.
  - eoc_i is ignored in IDLE; no check, no count.
- State TRACK: held<=vin_i every cycle while sample_i=1; sample_i=0 -> HOLD, held frozen at the last tracked value.
- State HOLD:
  - held is frozen.
  - eoc_i=1 -> CHECK, with result_i captured at that edge.
  - sample_i=1 without a prior eoc_i abandons the conversion: go to TRACK, held<=vin_i, no count.
  - If sample_i and eoc_i are both 1, eoc_i wins (check first). Sample is then re-evaluated from CHECK.
- State CHECK (one cycle):
  - done_o=1.
  - pass_o<=(captured result == exp).
  - conv_cnt_o+1 and, on mismatch, err_cnt_o+1; each counter saturates at 2^CntWidth-1 and holds.
  - Next state: TRACK (held<=vin_i) if sample_i=1, else IDLE.
- done_o is high only in the CHECK cycle.
- pass_o holds its value until the next check.
- eoc_i held high across several cycles produces only one check. A new check requires passing through TRACK again.
- Offset changes during HOLD take effect on raw immediately. exp uses offset_i sampled at the eoc_i edge.

Test Plan:
- Reset: assert rst_i 2 cycles mid-TRACK -> all outputs 0 on the next edge; counters 0; state IDLE.
- Basic, Width=6, Latency=1, offset 0: vin=37, sample high 3 cycles then low.
  - dac 32 -> cmp_o=1 one cycle later; dac 48 -> cmp_o=0; dac 37 -> cmp_o=1.
  - eoc with result 37 -> done_o pulse, pass_o=1, conv_cnt 1, err_cnt 0.
- Mismatch: vin=20, offset 0, controller result forced to 21 -> pass_o=0, err_cnt 1.
- Offset and clamp: vin=1, offset -4 -> eff=-3; dac 0 gives cmp_o=0; exp=0; result 0 passes. Then vin=63, offset +3 -> dac 63 gives cmp_o=1; exp=63.
- Latency=3: step dac_i 16->48 with held=30 -> cmp_o stays 1 for 2 further cycles and drops on the 3rd edge after the step.
- Boundaries:
  - eoc_i held 4 cycles -> exactly one done_o.
  - Resample in HOLD without eoc -> conv_cnt unchanged.
  - CntWidth=2: 5 failing conversions -> both counters saturate at 3.
